// File: rtl/qpu_dtcm_pkg.sv
// -----------------------------------------------------------------------------
// qpu_dtcm_pkg
// Shared definitions for the two-master DTCM controller:
//   - default SRAM geometry (word address, data and byte-mask widths)
//   - default idle threshold for SRAM light-sleep entry
//   - master port identifiers
//   - response-buffer entry layout at the default data width
//   - credit helper used by the arbiter
// -----------------------------------------------------------------------------
package qpu_dtcm_pkg;

    localparam int RAM_AW_DEF      = 12;
    localparam int RAM_DW_DEF      = 32;
    localparam int RAM_MW_DEF      = RAM_DW_DEF / 8;
    localparam int IDLE_CYCLES_DEF = 16;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // One buffered response: owning port plus read data (zero for writes).
    typedef struct packed {
        logic                  id;
        logic [RAM_DW_DEF-1:0] rdata;
    } rsp_entry_t;

    // A new command may only be accepted when the buffered responses plus the
    // access still travelling through the SRAM leave room in the 2-entry buffer.
    function automatic logic has_credit(input logic [1:0] count, input logic inflight);
        return ({1'b0, count} + {2'b00, inflight}) < 3'd2;
    endfunction

endpackage

// File: rtl/qpu_dtcm_rsp_fifo.sv
// -----------------------------------------------------------------------------
// qpu_dtcm_rsp_fifo
// Two-entry synchronous FIFO holding in-order responses for both masters.
// Push and pop in the same cycle are allowed (count unchanged); a pop while
// empty is ignored. Pointers are single bits and wrap modulo 2.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (control state only)
//   push_i        write push_data_i at the tail
//   push_data_i   entry to store (W bits)
//   pop_i         drop the head entry
//   head_o        entry at the head (meaningful only when !empty_o)
//   count_o       number of stored entries (0..2)
//   empty_o       no entries stored
// -----------------------------------------------------------------------------
module qpu_dtcm_rsp_fifo
    import qpu_dtcm_pkg::*;
#(
    parameter int W = $bits(rsp_entry_t)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o,
    output logic         empty_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    assign do_pop  = pop_i & (count_q != 2'd0);
    // A full buffer can still take a push when the head leaves in the same cycle.
    assign do_push = push_i & ((count_q != 2'd2) | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/qpu_dtcm_ctrl.sv
// -----------------------------------------------------------------------------
// qpu_dtcm_ctrl
// Two-master DTCM controller driving a single-port SRAM wrapper with 1-cycle
// read latency. Port A (LSU) and port B (loader bus) each have a valid/ready
// command channel and a valid/ready response channel. One SRAM access per
// cycle, round-robin arbitration on contention, responses returned strictly
// in order through a shared 2-entry buffer.
//
// Build option:
//   QPU_DTCM_CTRL_LS_EN  when defined, ram_ls is raised after IDLE_CYCLES idle
//                        cycles; a command then wakes the SRAM with one cycle
//                        of penalty. When undefined ram_ls is tied to 0.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   {a,b}_cmd_valid/ready            command handshake
//   {a,b}_cmd_read                   1 = read, 0 = write
//   {a,b}_cmd_addr                   byte address, bits [1:0] ignored
//   {a,b}_cmd_wdata/wmask            write data and byte mask
//   {a,b}_rsp_valid/ready            response handshake
//   {a,b}_rsp_rdata                  read data (0 for writes / when not valid)
//   ram_cs, ram_we, ram_addr         SRAM select, write, word address
//   ram_wem, ram_din                 SRAM byte write mask and write data
//   ram_dout                         SRAM read data, valid the cycle after cs
//   ram_sd, ram_ds, ram_ls           SRAM power controls (sd/ds tied 0)
// -----------------------------------------------------------------------------
module qpu_dtcm_ctrl
    import qpu_dtcm_pkg::*;
#(
    parameter int RAM_AW      = RAM_AW_DEF,
    parameter int RAM_DW      = RAM_DW_DEF,
    parameter int RAM_MW      = RAM_MW_DEF,
    parameter int IDLE_CYCLES = IDLE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_cmd_valid,
    output logic              a_cmd_ready,
    input  logic              a_cmd_read,
    input  logic [RAM_AW+1:0] a_cmd_addr,
    input  logic [RAM_DW-1:0] a_cmd_wdata,
    input  logic [RAM_MW-1:0] a_cmd_wmask,
    output logic              a_rsp_valid,
    input  logic              a_rsp_ready,
    output logic [RAM_DW-1:0] a_rsp_rdata,

    input  logic              b_cmd_valid,
    output logic              b_cmd_ready,
    input  logic              b_cmd_read,
    input  logic [RAM_AW+1:0] b_cmd_addr,
    input  logic [RAM_DW-1:0] b_cmd_wdata,
    input  logic [RAM_MW-1:0] b_cmd_wmask,
    output logic              b_rsp_valid,
    input  logic              b_rsp_ready,
    output logic [RAM_DW-1:0] b_rsp_rdata,

    output logic              ram_cs,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [RAM_MW-1:0] ram_wem,
    output logic [RAM_DW-1:0] ram_din,
    input  logic [RAM_DW-1:0] ram_dout,
    output logic              ram_sd,
    output logic              ram_ds,
    output logic              ram_ls
);

    typedef struct packed {
        logic              id;
        logic [RAM_DW-1:0] rdata;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // run_q keeps the command side closed while reset is asserted, so every
    // output is 0 during reset even if a master holds cmd_valid high.
    logic run_q;
    logic prio_q, prio_d;
    logic inflight_q, inflight_d;
    logic inf_id_q, inf_id_d;
    logic inf_rd_q, inf_rd_d;

    logic              any_valid;
    logic              winner;
    logic              credit;
    logic              ls_block;
    logic              hs;
    logic              win_read;
    logic [RAM_AW+1:0] win_addr;
    logic [RAM_DW-1:0] win_wdata;
    logic [RAM_MW-1:0] win_mask;

    entry_t     inflight_entry;
    entry_t     fifo_head;
    entry_t     rsp_head;
    logic [1:0] fifo_count;
    logic       fifo_empty;
    logic       fifo_push;
    logic       fifo_pop;
    logic       rsp_avail;
    logic       pop_any;

    logic unused_addr_lsb;

    // ------------------------------------------------------------------
    // Arbitration: prio_q names the port that wins the next contention.
    // ------------------------------------------------------------------
    always_comb begin
        any_valid = a_cmd_valid | b_cmd_valid;
        if (a_cmd_valid && b_cmd_valid) begin
            winner = prio_q;
        end else if (b_cmd_valid) begin
            winner = PORT_B;
        end else begin
            winner = PORT_A;
        end
        credit = has_credit(fifo_count, inflight_q);
        hs     = run_q & credit & ~ls_block & any_valid;
    end

    assign a_cmd_ready = hs & (winner == PORT_A);
    assign b_cmd_ready = hs & (winner == PORT_B);

    always_comb begin
        win_read  = a_cmd_read;
        win_addr  = a_cmd_addr;
        win_wdata = a_cmd_wdata;
        win_mask  = a_cmd_wmask;
        if (winner == PORT_B) begin
            win_read  = b_cmd_read;
            win_addr  = b_cmd_addr;
            win_wdata = b_cmd_wdata;
            win_mask  = b_cmd_wmask;
        end
    end

    assign unused_addr_lsb = ^win_addr[1:0];

    // ------------------------------------------------------------------
    // SRAM drive: everything is zero outside a handshake cycle.
    // ------------------------------------------------------------------
    always_comb begin
        ram_cs   = hs;
        ram_we   = hs & ~win_read;
        ram_addr = hs ? win_addr[RAM_AW+1:2] : '0;
        ram_wem  = (hs & ~win_read) ? win_mask : '0;
        ram_din  = (hs & ~win_read) ? win_wdata : '0;
    end

    assign ram_sd = 1'b0;
    assign ram_ds = 1'b0;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_comb begin
        prio_d     = hs ? ~winner : prio_q;
        inflight_d = hs;
        inf_id_d   = hs ? winner : inf_id_q;
        inf_rd_d   = hs ? win_read : inf_rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            prio_q     <= PORT_A;
            inflight_q <= 1'b0;
            inf_id_q   <= PORT_A;
            inf_rd_q   <= 1'b0;
        end else begin
            run_q      <= 1'b1;
            prio_q     <= prio_d;
            inflight_q <= inflight_d;
            inf_id_q   <= inf_id_d;
            inf_rd_q   <= inf_rd_d;
        end
    end

    // ------------------------------------------------------------------
    // Response path. The access in flight is logically the entry behind the
    // buffer tail: when the buffer is empty it is presented directly (giving
    // a 1-cycle response), and it is only stored if it is not consumed in
    // that same cycle. This keeps 1 access/cycle while responses drain.
    // ------------------------------------------------------------------
    always_comb begin
        inflight_entry.id    = inf_id_q;
        inflight_entry.rdata = inf_rd_q ? ram_dout : '0;
        rsp_head             = fifo_empty ? inflight_entry : fifo_head;
        rsp_avail            = ~fifo_empty | inflight_q;
    end

    assign a_rsp_valid = rsp_avail & (rsp_head.id == PORT_A);
    assign b_rsp_valid = rsp_avail & (rsp_head.id == PORT_B);
    assign a_rsp_rdata = a_rsp_valid ? rsp_head.rdata : '0;
    assign b_rsp_rdata = b_rsp_valid ? rsp_head.rdata : '0;

    assign pop_any   = (a_rsp_valid & a_rsp_ready) | (b_rsp_valid & b_rsp_ready);
    assign fifo_pop  = pop_any & ~fifo_empty;
    assign fifo_push = inflight_q & ~(fifo_empty & pop_any);

    qpu_dtcm_rsp_fifo #(
        .W (ENTRY_W)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i (inflight_entry),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Light sleep
    // ------------------------------------------------------------------
`ifdef QPU_DTCM_CTRL_LS_EN
    localparam logic [7:0] IDLE_THR = 8'(IDLE_CYCLES);

    logic [7:0] idle_cnt_q, idle_cnt_d;
    logic       ls_q, ls_d;

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        ls_d       = ls_q;
        if (any_valid) begin
            // Wake request: sleep drops at the next edge, commands wait one cycle.
            idle_cnt_d = '0;
            ls_d       = 1'b0;
        end else if (inflight_q || !fifo_empty) begin
            idle_cnt_d = '0;
        end else begin
            if (idle_cnt_q != 8'hFF) begin
                idle_cnt_d = idle_cnt_q + 8'd1;
            end
            if (idle_cnt_d >= IDLE_THR) begin
                ls_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
            ls_q       <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            ls_q       <= ls_d;
        end
    end

    assign ls_block = ls_q;
    assign ram_ls   = ls_q;
`else
    logic unused_idle_cfg;

    assign unused_idle_cfg = (IDLE_CYCLES != 0);
    assign ls_block        = 1'b0;
    assign ram_ls          = 1'b0;
`endif

endmodule

// File: doc/qpu_dtcm_ctrl.md
Name: qpu_dtcm_ctrl

Overview:
- Two-master DTCM controller sitting directly upstream of the DTCM SRAM wrapper; drives its cs/we/addr/wem/din and consumes dout.
- Masters: port A (LSU) and port B (external/loader bus). Each uses a valid/ready command channel and a valid/ready response channel.
- Round-robin arbitration, one SRAM access per cycle, 1-cycle SRAM read latency, shared 2-entry in-order response buffer.

Parameters:
- RAM_AW, 12, SRAM word-address width.
- RAM_DW, 32, data width.
- RAM_MW, 4, write-enable mask width (RAM_DW/8).
- IDLE_CYCLES, 16, idle cycles before light-sleep entry (optional feature only).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- a_cmd_valid / b_cmd_valid  in  1  command valid
- a_cmd_ready / b_cmd_ready  out  1  command accepted
- a_cmd_read / b_cmd_read  in  1  1=read, 0=write
- a_cmd_addr / b_cmd_addr  in  RAM_AW+2  byte address; bits [1:0] ignored
- a_cmd_wdata / b_cmd_wdata  in  RAM_DW  write data
- a_cmd_wmask / b_cmd_wmask  in  RAM_MW  byte write mask
- a_rsp_valid / b_rsp_valid  out  1  response valid
- a_rsp_ready / b_rsp_ready  in  1  response accepted
- a_rsp_rdata / b_rsp_rdata  out  RAM_DW  read data (0 for writes)
- ram_cs, ram_we  out  1  SRAM select, write
- ram_addr  out  RAM_AW  word address = cmd_addr[RAM_AW+1:2]
- ram_wem  out  RAM_MW  wmask on writes, 0 on reads
- ram_din  out  RAM_DW  write data
- ram_dout  in  RAM_DW  SRAM read data, valid the cycle after cs
- ram_sd, ram_ds, ram_ls  out  1  power controls; sd/ds tied 0

Behaviour:
- Reset (async, rst_n=0): all outputs 0, buffer empty, inflight=0, rr pointer=A, idle counter=0. Any in-flight access is discarded; no response is produced for it.
- Space check: credit = (buf_count + inflight) < 2. Without credit, both cmd_ready are 0.
- Arbitration with credit: only one valid wins. If both are valid, the port not granted last wins (rr); rr updates only on a handshake.
- cmd_ready is asserted only to the winner. This is combinational from valid and credit, which is allowed; ready never depends on ready.
- Handshake cycle: ram_cs=1, ram_we=!read, addr/wem/din driven from the winner. inflight<=1 with port id and read flag registered.
- Cycle after the handshake: push {id, read ? ram_dout : 0} into the buffer. Read latency from command handshake to rsp_valid is 1 cycle.
- Responses are in order from buffer head. a_rsp_valid = !empty & head_id==A; b likewise. rsp_rdata is driven from head and is 0 when not valid.
- Head-of-line blocking across ports is accepted.
- Push and pop in the same cycle are allowed; count is unchanged. Full (count 2) blocks new commands only.
- Pop on rsp_valid & rsp_ready. Back-to-back throughput is 1 access/cycle while responses drain every cycle.
- Read and write to the same address on consecutive cycles: the SRAM order is preserved, so the read returns the new data.
- Buffer pointers wrap modulo 2.

Optional Feature:
- Macro QPU_DTCM_CTRL_LS_EN.
- Defined:
  - 8-bit idle counter increments while no cmd_valid, inflight=0 and buffer empty; it saturates.
  - At IDLE_CYCLES the counter sets ram_ls=1.
  - While ram_ls=1, any cmd_valid clears ram_ls at the next edge, and cmd_ready stays 0 in that wake cycle. This gives a 1-cycle wake penalty.
  - ram_cs is never 1 while ram_ls=1.
  - Any activity resets the counter.
- Undefined: ram_ls constant 0, no counter, no wake penalty.

Decomposition:
- Package qpu_dtcm_pkg: RAM_AW/DW/MW defaults, IDLE_CYCLES default, PORT_A=0/PORT_B=1 constants, response-entry struct {id, rdata}.
- One natural sub-module: qpu_dtcm_rsp_fifo, a 2-entry synchronous FIFO with push, pop, count, head.

Test Plan:
- Reset: hold rst_n=0 with a_cmd_valid=1. All outputs 0. Release, then write A 0x0010 data 0xDEADBEEF mask 0xF: ram_cs=1, we=1, addr=0x004; a_rsp_valid next cycle with rdata 0.
- Byte mask and read-after-write: write 0x11223344 mask 0xF, then write 0xAA mask 0x1 to 0x20, then read 0x20. Read response rdata=0x112233AA, 1 cycle after the handshake.
- Round robin: A and B both read continuously with rsp_ready=1. Grants alternate A,B,A,B; 1 access/cycle; each port gets its own data.
- Backpressure: a_rsp_ready=0, A issues 3 reads. The first 2 are accepted and the third gets cmd_ready=0 until a pop. B is blocked behind the A head.
- Reset mid-op: assert rst_n=0 in the cycle after a read handshake. No rsp_valid after release, and buffer count is 0.
- LS_EN: 16 idle cycles give ram_ls=1. Then a_cmd_valid: ram_ls=0 next cycle, handshake one cycle later, ram_cs never overlaps ram_ls.
